// File: rtl/seq_div_4b2_pkg.sv
// Shared types and constants for the 4-bit by 2-bit sequential restoring divider.
// Holds the FSM state enum, the operand widths and the divide-by-zero quotient code.
package seq_div_4b2_pkg;

    localparam int DIVIDEND_W = 4;
    localparam int DIVISOR_W  = 2;
    localparam int PREM_W     = 3;
    localparam int CNT_W      = 2;

    localparam logic [DIVIDEND_W-1:0] DIV_ZERO_QUOTIENT = 4'hF;
    localparam logic [CNT_W-1:0]      LAST_STEP         = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_div_4b2_pkg

// File: rtl/seq_div_4b2_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// the divisor, and keep or restore the partial remainder.
module seq_div_4b2_div_step
    import seq_div_4b2_pkg::*;
(
    input  logic [PREM_W-1:0]    prem_i,
    input  logic                 dividend_bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [PREM_W-1:0]    prem_o,
    output logic                 q_bit_o
);

    logic [PREM_W:0]   shifted;
    logic [PREM_W:0]   divisor_ext;
    logic [PREM_W-1:0] trial;

    // The shifted MSB is always zero because the partial remainder stays below the
    // divisor; it is still part of the compare so the step is correct on its own.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
        shifted     = {prem_i, dividend_bit_i};
        divisor_ext = {{(PREM_W + 1 - DIVISOR_W){1'b0}}, divisor_i};
        trial       = shifted[PREM_W-1:0] - divisor_ext[PREM_W-1:0];
        q_bit_o     = (shifted >= divisor_ext);
        prem_o      = q_bit_o ? trial : shifted[PREM_W-1:0];
    end

endmodule : seq_div_4b2_div_step

// File: rtl/seq_div_4b2.sv
// Sequential 4-bit / 2-bit unsigned restoring divider, one quotient bit per cycle.
// Holds the control FSM, the step counter and the operand/result registers.
module seq_div_4b2
    import seq_div_4b2_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [PREM_W-1:0]     prem_q;
    logic [DIVIDEND_W-1:0] work_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  div_zero_q;

    logic [PREM_W-1:0]     prem_d;
    logic                  q_bit_d;
    logic [DIVIDEND_W-1:0] work_d;

    seq_div_4b2_div_step div_step (
        .prem_i         (prem_q),
        .dividend_bit_i (work_q[DIVIDEND_W-1]),
        .divisor_i      (dvs_q),
        .prem_o         (prem_d),
        .q_bit_o        (q_bit_d)
    );

    // work_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    assign work_d = {work_q[DIVIDEND_W-2:0], q_bit_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        work_q <= dividend;
                        dvs_q  <= divisor;
                        prem_q <= '0;
                        cnt_q  <= '0;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            quotient_q  <= DIV_ZERO_QUOTIENT;
                            remainder_q <= '0;
                            div_zero_q  <= 1'b1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q    <= CALC;
                            div_zero_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= work_d;
                        remainder_q <= prem_d[DIVISOR_W-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;

endmodule : seq_div_4b2

// File: doc/seq_div_4b2.md
SEQ_DIV_4B2 -- requirements
Module: seq_div_4b2

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled on the rising clk edge.
REQ-005 dividend  input  4  unsigned dividend; sampled only on an accepted start.
REQ-006 divisor  input  2  unsigned divisor; sampled only on an accepted start.
REQ-007 quotient  output  4  unsigned quotient; registered.
REQ-008 remainder  output  2  unsigned remainder; registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  single-cycle pulse when a result becomes valid.
REQ-011 div_zero  output  1  high with the result when divisor was 0.

Function
REQ-012 The block SHALL compute dividend = quotient*divisor + remainder, with remainder < divisor, using restoring division at one quotient bit per cycle, MSB first.
REQ-013 The state machine SHALL have states IDLE, CALC and DONE.
REQ-014 A start SHALL be accepted only when busy=0, i.e. in IDLE or DONE.
- start is ignored in CALC.
- Operands are latched internally on acceptance.
REQ-015 On an accepted start with divisor != 0, the block SHALL go to CALC, with busy=1 from the next cycle and a 2-bit iteration counter cleared to 0.
REQ-016 Each CALC cycle SHALL run one step:
- Shift the 3-bit partial remainder left, bringing in the next dividend bit.
- Trial-subtract the zero-extended divisor.
- If the result is non-negative: keep it and set the quotient bit to 1.
- Otherwise: restore the partial remainder and set the quotient bit to 0.
REQ-017 After exactly 4 CALC cycles (counter wraps 3->0), the block SHALL enter DONE.
- quotient and remainder are loaded.
- done=1 and busy=0 for exactly that one cycle.
REQ-018 Latency SHALL be fixed:
- Start sampled at edge k gives busy high during cycles k+1..k+4.
- done is high in cycle k+5.
REQ-019 On an accepted start with divisor=0, the block SHALL go directly to DONE at the next edge.
- quotient=4'hF, remainder=2'b00, div_zero=1, done=1.
- busy is never asserted.
REQ-020 div_zero SHALL clear on the next accepted start and hold otherwise.
REQ-021 quotient and remainder SHALL hold their last result until the next DONE; they are not updated during CALC.
REQ-022 DONE SHALL return to IDLE on the next edge unless a start is accepted in that cycle, in which case the block goes to CALC (back-to-back operation).
REQ-023 dividend=0 SHALL follow the normal 4-cycle path and give quotient=0, remainder=0.

Reset
REQ-024 When rst=1, independent of clk, the block SHALL force:
- state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_zero=0.
- Internal partial remainder, counter and latched operands cleared.
REQ-025 Reset asserted mid-CALC SHALL abort the division with no done pulse, and the first rising edge after rst deasserts SHALL see IDLE.

Structure
REQ-026 A shared package SHALL hold:
- the state enum (IDLE, CALC, DONE);
- the width constants DIVIDEND_W=4, DIVISOR_W=2, PREM_W=3;
- the zero-divide quotient constant 4'hF.
REQ-027 The combinational restoring step (shift, trial subtract, select, quotient bit) SHALL be a sub-module div_step, instantiated once and reused each CALC cycle.
REQ-028 The top level SHALL contain only the FSM, the counter and the registers.

Verification
REQ-029 Start with dividend=13, divisor=3 -> done 5 cycles after start, quotient=4, remainder=1, div_zero=0.
REQ-030 Start with dividend=15, divisor=1 -> quotient=15, remainder=0; then 2/3 back-to-back, started in the DONE cycle -> quotient=0, remainder=2 five cycles later.
REQ-031 Start with dividend=9, divisor=0 -> next cycle done=1, div_zero=1, quotient=4'hF, remainder=0, busy never high.
REQ-032 Start with 12/2, then pulse start with 7/1 during CALC -> the second start is ignored and the result is quotient=6, remainder=0.
REQ-033 Assert rst during the 2nd CALC cycle of 11/3 -> all outputs 0 immediately, no done pulse; a new 11/3 afterwards gives quotient=3, remainder=2.
REQ-034 Exhaustive run over all 64 dividend/divisor pairs -> quotient*divisor+remainder=dividend and remainder<divisor for every pair with divisor!=0.
